// File: rtl/gshare_bht.sv
// gshare branch predictor: PC xor global history indexes a table of saturating counters.
// Optional performance counters are compiled in when BHT_PERF_CNT_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | walk the table writing weakly-not-taken, one entry per cycle
// ST_RUN  | predictions and training live; terminal until reset
module gshare_bht #(
  parameter int IDX_W = 10,
  parameter int CTR_W = 2,
  parameter int GHR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lookup_PC,
  input  logic             lookup_valid,
  output logic             predict_taken,
  output logic [GHR_W-1:0] predict_ghr,
  output logic             ready,
  input  logic             update_enable,
  input  logic [31:0]      update_PC,
  input  logic [GHR_W-1:0] update_ghr,
  input  logic             update_taken,
  input  logic             update_mispredict
`ifdef BHT_PERF_CNT_EN
  ,
  output logic [31:0]      perf_lookups,
  output logic [31:0]      perf_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0] table_q [DEPTH];

  logic             run;
  logic [IDX_W-1:0] lookup_idx, update_idx;
  logic [CTR_W-1:0] lookup_ctr, update_ctr;
  logic [GHR_W-1:0] ghr_repair, ghr_shift;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;

  assign run        = (state_q == ST_RUN);
  assign lookup_idx = lookup_PC[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign update_idx = update_PC[IDX_W+1:2] ^ IDX_W'(update_ghr);
  assign lookup_ctr = table_q[lookup_idx];
  assign update_ctr = table_q[update_idx];

  assign ready         = run;
  assign predict_taken = run & lookup_ctr[CTR_W-1];
  assign predict_ghr   = ghr_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_PC[31:IDX_W+2], lookup_PC[1:0],
                            update_PC[31:IDX_W+2], update_PC[1:0]};

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_repair = update_taken;
      assign ghr_shift  = predict_taken;
    end else begin : g_ghr_multi
      assign ghr_repair = {update_ghr[GHR_W-2:0], update_taken};
      assign ghr_shift  = {ghr_q[GHR_W-2:0], predict_taken};
    end
  endgenerate

  // Single write port: the init walk owns it until RUN, then training does.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = CTR_WNT;
    if (!run) begin
      wr_en = 1'b1;
    end else if (update_enable) begin
      wr_en  = 1'b1;
      wr_idx = update_idx;
      if (update_taken)
        wr_data = (update_ctr == CTR_MAX) ? update_ctr : update_ctr + CTR_W'(1);
      else
        wr_data = (update_ctr == '0) ? update_ctr : update_ctr - CTR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + IDX_W'(1);
        ghr_d = '0;
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A mispredict repair wins over the speculative shift from fetch.
        if (update_enable && update_mispredict) ghr_d = ghr_repair;
        else if (lookup_valid)                  ghr_d = ghr_shift;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) table_q[wr_idx] <= wr_data;
  end

`ifdef BHT_PERF_CNT_EN
  logic [31:0] perf_lk_q, perf_mp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lk_q <= '0;
      perf_mp_q <= '0;
    end else if (run) begin
      if (lookup_valid && !(&perf_lk_q)) perf_lk_q <= perf_lk_q + 32'd1;
      if (update_enable && update_mispredict && !(&perf_mp_q))
        perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_lookups     = perf_lk_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboard bench for gshare_bht (IDX_W=4, GHR_W=4): a driver pushes expected outputs
// from an array/arithmetic model, a negedge monitor pops and compares.
module tb_gshare_bht;
  localparam int IDX_W = 4;
  localparam int CTR_W = 2;
  localparam int GHR_W = 4;
  localparam int N     = 1 << IDX_W;
  localparam int HMOD  = 1 << GHR_W;
  localparam int CMAX  = (1 << CTR_W) - 1;
  localparam int WNT   = (1 << (CTR_W - 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [31:0]      lookup_PC;
  logic             lookup_valid;
  logic             predict_taken;
  logic [GHR_W-1:0] predict_ghr;
  logic             ready;
  logic             update_enable;
  logic [31:0]      update_PC;
  logic [GHR_W-1:0] update_ghr;
  logic             update_taken;
  logic             update_mispredict;
`ifdef BHT_PERF_CNT_EN
  logic [31:0]      perf_lookups, perf_mispredicts;
`endif

  gshare_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_PC(lookup_PC), .lookup_valid(lookup_valid),
    .predict_taken(predict_taken), .predict_ghr(predict_ghr), .ready(ready),
    .update_enable(update_enable), .update_PC(update_PC), .update_ghr(update_ghr),
    .update_taken(update_taken), .update_mispredict(update_mispredict)
`ifdef BHT_PERF_CNT_EN
    , .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
`endif
  );

  typedef struct {
    logic             rdy;
    logic             pt;
    logic [GHR_W-1:0] ghr;
    logic [31:0]      pl;
    logic [31:0]      pm;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: counters as plain ints, history as an int modulo 2^GHR_W.
  int m_ctr[N];
  int m_ghr = 0, m_ready = 0, m_left = N, m_pl = 0, m_pm = 0;

  function automatic int idx_of(input logic [31:0] pc, input int hist);
    return int'((pc >> 2) % 32'(N)) ^ hist;
  endfunction

  function automatic int m_pred(input logic [31:0] pc);
    if (m_ready == 0) return 0;
    return (m_ctr[idx_of(pc, m_ghr)] > WNT) ? 1 : 0;
  endfunction

  task automatic step(input logic r, input logic lv, input logic [31:0] lpc,
                      input logic ue, input logic [31:0] upc, input int ughr,
                      input logic ut, input logic um, input bit chk, input string tag);
    exp_t e;
    int   pred, ui;
    rst = r; lookup_valid = lv; lookup_PC = lpc;
    update_enable = ue; update_PC = upc; update_ghr = GHR_W'(ughr);
    update_taken = ut; update_mispredict = um;
    pred = m_pred(lpc);
    if (chk) begin
      e.rdy = m_ready[0]; e.pt = pred[0]; e.ghr = GHR_W'(m_ghr);
      e.pl = 32'(m_pl); e.pm = 32'(m_pm); e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!r) begin
      m_ready = 0; m_left = N; m_ghr = 0; m_pl = 0; m_pm = 0;
    end else if (m_ready == 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        foreach (m_ctr[i]) m_ctr[i] = WNT;
      end
    end else begin
      if (ue) begin
        ui = idx_of(upc, ughr % HMOD);
        if (ut) m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
        else    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end
      if (lv) m_pl++;
      if (ue && um) begin
        m_pm++;
        m_ghr = ((ughr * 2) + int'(ut)) % HMOD;
      end else if (lv) begin
        m_ghr = ((m_ghr * 2) + pred) % HMOD;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc, input string tag);
    step(1'b1, 1'b0, lpc, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic rand_step(input logic r, input string tag);
    logic [31:0] lpc, upc;
    lpc = 32'($urandom_range(0, 63)) << 2;
    upc = 32'($urandom_range(0, 63)) << 2;
    step(r, 1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 2) != 0), upc,
         int'($urandom_range(0, HMOD - 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 3) == 0), 1'b1, tag);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ready !== e.rdy) begin
        errors++;
        $display("FAIL %s ready: got %b want %b @%0t", e.tag, ready, e.rdy, $time);
      end
      checks++;
      if (predict_taken !== e.pt) begin
        errors++;
        $display("FAIL %s predict_taken: got %b want %b @%0t", e.tag, predict_taken, e.pt, $time);
      end
      checks++;
      if (predict_ghr !== e.ghr) begin
        errors++;
        $display("FAIL %s predict_ghr: got %h want %h @%0t", e.tag, predict_ghr, e.ghr, $time);
      end
`ifdef BHT_PERF_CNT_EN
      checks++;
      if (perf_lookups !== e.pl || perf_mispredicts !== e.pm) begin
        errors++;
        $display("FAIL %s perf: got %0d/%0d want %0d/%0d @%0t", e.tag,
                 perf_lookups, perf_mispredicts, e.pl, e.pm, $time);
      end
`endif
    end
  end

  initial begin
    foreach (m_ctr[i]) m_ctr[i] = 0;
    // First edge establishes reset state; nothing is defined before it.
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, "pre");
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b1, 1'b1, "reset");
    // Init walk with lookups/updates that must be ignored.
    for (int i = 0; i < N + 3; i++)
      step(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 3, 1'b1, 1'b1, 1'b1, "init");

    // Training at PC 0x40 with history 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b0, 1'b1, "train_up");
      idle(32'h40, "train_up_chk");
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 0, 1'b0, 1'b0, 1'b1, "train_dn");
      idle(32'h40, "train_dn_chk");
    end

    // Speculative history shifting, then lookup at PC 0.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 32'($urandom_range(0, 15)) << 2, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1, "shift");
    idle(32'h0, "hist_lookup");

    // Repair beats the same-cycle shift: next GHR = 0101.
    step(1'b1, 1'b1, 32'h0, 1'b1, 32'h80, 2, 1'b1, 1'b1, 1'b1, "repair");
    idle(32'h0, "repair_chk");

    // Same-index lookup and taken update: old value now, new value next cycle.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h1C, 1'b1, 32'h1C, m_ghr, 1'b1, 1'b0, 1'b1, "same_idx");
      idle(32'h1C, "same_idx_next");
    end

    for (int i = 0; i < 1500; i++) rand_step(1'b1, "rand");

    // Mid-run reset, then mid-init reset, then another random run.
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 0, 1'b1, 1'b1, 1'b1, "rst_run");
    for (int i = 0; i < N / 2; i++) rand_step(1'b1, "reinit");
    step(1'b0, 1'b0, 32'h40, 1'b0, 32'h40, 0, 1'b0, 1'b0, 1'b1, "rst_init");
    for (int i = 0; i < 800; i++) rand_step(1'b1, "rand2");

    idle(32'h0, "tail");
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
